// File: rtl/pipelined_imem.sv
// Synchronous instruction memory with a registered read, valid/ready request and
// response handshakes, a program-load write port, alignment and range fault
// reporting, flush, and a last-word buffer that avoids redundant array reads.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     fetch request handshake (req_ready is combinational)
//   req_addr [AW]           byte address of the instruction
//   rsp_valid/rsp_ready     response handshake (single-entry output register)
//   rsp_data [XLEN]         instruction word, NOP_WORD on a fault
//   rsp_fault               misaligned or out-of-range request
//   flush                   drop the pending response, block acceptance this cycle
//   load_en/addr/data       program-load write port
//   mem_access              combinational; high in a cycle where the array is read
module pipelined_imem #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 256,
  parameter int unsigned     AW       = 32,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(32'h0000_0013)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AW-1:0]            req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_data,
  output logic                     rsp_fault,
  input  logic                     flush,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [XLEN-1:0]          load_data,
  output logic                     mem_access
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];

  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_data_q,  rsp_data_d;
  logic            rsp_fault_q, rsp_fault_d;
  logic            buf_valid_q, buf_valid_d;
  logic [IW-1:0]   buf_idx_q,   buf_idx_d;
  logic [XLEN-1:0] buf_data_q,  buf_data_d;

  logic            accept;
  logic [IW-1:0]   idx;
  logic            fault;
  logic            ld_same;
  logic            hit;
  logic [XLEN-1:0] rd_data;

  // Request decode, buffer lookup and write-first bypass
  always_comb begin
    req_ready  = !flush && (!rsp_valid_q || rsp_ready);
    accept     = req_valid && req_ready && rst_n;
    idx        = req_addr[2 +: IW];
    // any address bit above the word index makes the request out of range
    fault      = (req_addr[1:0] != 2'b00) || ((req_addr >> (2 + IW)) != '0);
    ld_same    = load_en && (load_addr == idx);
    // a load to the buffered index invalidates it this cycle, so it cannot hit
    hit        = buf_valid_q && (buf_idx_q == idx) && !ld_same;
    rd_data    = ld_same ? load_data : mem_q[idx];
    mem_access = accept && !fault && !hit;
  end

  // Response register and last-word buffer next state
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    buf_valid_d = buf_valid_q;
    buf_idx_d   = buf_idx_q;
    buf_data_d  = buf_data_q;

    if (load_en && (load_addr == buf_idx_q)) begin
      buf_valid_d = 1'b0;
    end

    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_fault_d = fault;
      if (fault) begin
        rsp_data_d = NOP_WORD;
      end else if (hit) begin
        rsp_data_d = buf_data_q;
      end else begin
        rsp_data_d  = rd_data;
        buf_valid_d = 1'b1;
        buf_idx_d   = idx;
        buf_data_d  = rd_data;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_idx_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
      buf_valid_q <= buf_valid_d;
      buf_idx_q   <= buf_idx_d;
      buf_data_q  <= buf_data_d;
    end
  end

  // Array contents are not reset
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_fault = rsp_fault_q;

endmodule
